// File: rtl/multicycle_control_unit_if.sv
`default_nettype none
// ============================================================================
//  Module   : multicycle_control_unit_if
//  Purpose  : Bundles the instruction-decode inputs, the memory handshake and
//             the datapath strobes/selects/status of the multicycle control
//             unit into one port.
//  Ports    : op[5:0], func[5:0], z, mem_ready       (datapath -> control)
//             wpc, wir, wmem, wreg, iord, regrt, m2reg, shift, jal, sext,
//             alusrca, aluc[3:0], alusrcb[1:0], pcsource[1:0],
//             state[2:0], illegal, mem_timeout, icount[CNT_W-1:0]
//                                                    (control -> datapath)
//  Modports : master = control unit, slave = datapath side
//  Revision : 1.0  initial release
// ============================================================================
interface multicycle_control_unit_if #(
    parameter int CNT_W = 32
);
    logic [5:0]       op;
    logic [5:0]       func;
    logic             z;
    logic             mem_ready;

    logic             wpc;
    logic             wir;
    logic             wmem;
    logic             wreg;
    logic             iord;
    logic             regrt;
    logic             m2reg;
    logic             shift;
    logic             jal;
    logic             sext;
    logic             alusrca;
    logic [3:0]       aluc;
    logic [1:0]       alusrcb;
    logic [1:0]       pcsource;
    logic [2:0]       state;
    logic             illegal;
    logic             mem_timeout;
    logic [CNT_W-1:0] icount;

    modport master (
        input  op, func, z, mem_ready,
        output wpc, wir, wmem, wreg, iord, regrt, m2reg, shift, jal, sext,
               alusrca, aluc, alusrcb, pcsource, state, illegal,
               mem_timeout, icount
    );

    modport slave (
        output op, func, z, mem_ready,
        input  wpc, wir, wmem, wreg, iord, regrt, m2reg, shift, jal, sext,
               alusrca, aluc, alusrcb, pcsource, state, illegal,
               mem_timeout, icount
    );
endinterface
`default_nettype wire

// File: rtl/multicycle_control_unit.sv
`default_nettype none
// ============================================================================
//  Module   : multicycle_control_unit
//  Purpose  : Five-state (IF/ID/EXE/MEM/WB) control FSM for a MIPS-subset
//             multicycle datapath, with memory wait timeout, illegal opcode
//             detection and a retired-instruction counter.
//  Ports    : clk   - rising-edge clock
//             clrn  - asynchronous active-low reset
//             bus   - multicycle_control_unit_if.master (decode inputs,
//                     mem_ready, datapath strobes/selects, status)
//  Revision : 1.0  initial release
// ============================================================================
module multicycle_control_unit #(
    parameter int MEM_HANDSHAKE = 1,
    parameter int TIMEOUT       = 15,
    parameter int CNT_W         = 32
) (
    input  wire logic                 clk,
    input  wire logic                 clrn,
    multicycle_control_unit_if.master bus
);
    typedef enum logic [2:0] {
        S_IF  = 3'd0,
        S_ID  = 3'd1,
        S_EXE = 3'd2,
        S_MEM = 3'd3,
        S_WB  = 3'd4
    } state_t;

    // The abort fires on the TIMEOUT-th consecutive waiting cycle.
    localparam logic [7:0] c_WAIT_LAST = 8'(TIMEOUT - 1);

    state_t           r_state;
    state_t           w_next;
    logic [7:0]       r_wait;
    logic             r_mem_timeout;
    logic [CNT_W-1:0] r_icount;

    logic w_ready, w_waiting, w_timeout, w_retire;

    generate
        if (MEM_HANDSHAKE != 0) begin : g_handshake
            assign w_ready = bus.mem_ready;
        end else begin : g_fixed_timing
            assign w_ready = 1'b1;
        end
    endgenerate

    assign w_waiting = ((r_state == S_IF) || (r_state == S_MEM)) && !w_ready;
    assign w_timeout = w_waiting && (r_wait == c_WAIT_LAST);

    // ---------------------------------------------------------------- decode
    logic       w_is_legal, w_is_j, w_is_jal, w_is_jr, w_is_beq, w_is_bne;
    logic       w_is_lw, w_is_sw, w_is_imm, w_is_regrt, w_is_sext, w_is_shift;
    logic [3:0] w_dec_aluc;

    always_comb begin
        w_is_legal = 1'b1;
        w_is_j     = 1'b0;
        w_is_jal   = 1'b0;
        w_is_jr    = 1'b0;
        w_is_beq   = 1'b0;
        w_is_bne   = 1'b0;
        w_is_lw    = 1'b0;
        w_is_sw    = 1'b0;
        w_is_imm   = 1'b0;
        w_is_regrt = 1'b0;
        w_is_sext  = 1'b0;
        w_is_shift = 1'b0;
        w_dec_aluc = 4'b0010;
        case (bus.op)
            6'h00: begin
                case (bus.func)
                    6'h20: w_dec_aluc = 4'b0010;
                    6'h21: w_dec_aluc = 4'b0000;
                    6'h22: w_dec_aluc = 4'b0011;
                    6'h23: w_dec_aluc = 4'b0001;
                    6'h24: w_dec_aluc = 4'b0100;
                    6'h25: w_dec_aluc = 4'b0101;
                    6'h26: w_dec_aluc = 4'b0110;
                    6'h27: w_dec_aluc = 4'b0111;
                    6'h2A: w_dec_aluc = 4'b1011;
                    6'h2B: w_dec_aluc = 4'b1010;
                    6'h00: begin w_dec_aluc = 4'b1110; w_is_shift = 1'b1; end
                    6'h02: begin w_dec_aluc = 4'b1111; w_is_shift = 1'b1; end
                    6'h03: begin w_dec_aluc = 4'b1100; w_is_shift = 1'b1; end
                    6'h04: w_dec_aluc = 4'b1110;
                    6'h06: w_dec_aluc = 4'b1111;
                    6'h07: w_dec_aluc = 4'b1100;
                    6'h08: w_is_jr = 1'b1;
                    default: w_is_legal = 1'b0;
                endcase
            end
            6'h08: begin w_dec_aluc = 4'b0010; w_is_imm = 1'b1; w_is_regrt = 1'b1; w_is_sext = 1'b1; end
            6'h09: begin w_dec_aluc = 4'b0000; w_is_imm = 1'b1; w_is_regrt = 1'b1; w_is_sext = 1'b1; end
            6'h0C: begin w_dec_aluc = 4'b0100; w_is_imm = 1'b1; w_is_regrt = 1'b1; end
            6'h0D: begin w_dec_aluc = 4'b0101; w_is_imm = 1'b1; w_is_regrt = 1'b1; end
            6'h0E: begin w_dec_aluc = 4'b0110; w_is_imm = 1'b1; w_is_regrt = 1'b1; end
            6'h0A: begin w_dec_aluc = 4'b1011; w_is_imm = 1'b1; w_is_regrt = 1'b1; w_is_sext = 1'b1; end
            6'h0B: begin w_dec_aluc = 4'b1010; w_is_imm = 1'b1; w_is_regrt = 1'b1; w_is_sext = 1'b1; end
            6'h0F: begin w_dec_aluc = 4'b1000; w_is_imm = 1'b1; w_is_regrt = 1'b1; end
            6'h23: begin w_is_lw = 1'b1; w_is_imm = 1'b1; w_is_regrt = 1'b1; w_is_sext = 1'b1; end
            6'h2B: begin w_is_sw = 1'b1; w_is_imm = 1'b1; w_is_sext = 1'b1; end
            6'h04: begin w_is_beq = 1'b1; w_dec_aluc = 4'b0011; w_is_sext = 1'b1; end
            6'h05: begin w_is_bne = 1'b1; w_dec_aluc = 4'b0011; w_is_sext = 1'b1; end
            6'h02: w_is_j   = 1'b1;
            6'h03: w_is_jal = 1'b1;
            default: w_is_legal = 1'b0;
        endcase
    end

    // --------------------------------------------------- next state / outputs
    logic       w_wpc, w_wir, w_wmem, w_wreg, w_iord, w_regrt, w_m2reg;
    logic       w_shift, w_jal, w_sext, w_alusrca, w_illegal;
    logic [3:0] w_aluc;
    logic [1:0] w_alusrcb, w_pcsource;

    always_comb begin
        w_next     = S_IF;
        w_retire   = 1'b0;
        w_wpc      = 1'b0;
        w_wir      = 1'b0;
        w_wmem     = 1'b0;
        w_wreg     = 1'b0;
        w_iord     = 1'b0;
        w_regrt    = 1'b0;
        w_m2reg    = 1'b0;
        w_shift    = 1'b0;
        w_jal      = 1'b0;
        w_sext     = 1'b0;
        w_alusrca  = 1'b0;
        w_illegal  = 1'b0;
        w_aluc     = 4'b0000;
        w_alusrcb  = 2'b00;
        w_pcsource = 2'b00;
        case (r_state)
            S_IF: begin
                w_alusrcb = 2'b01;
                w_aluc    = 4'b0010;
                w_wir     = w_ready;
                w_wpc     = w_ready;
                // A timeout in IF simply restarts the fetch in place.
                w_next    = w_ready ? S_ID : S_IF;
            end
            S_ID: begin
                w_alusrcb = 2'b11;
                w_aluc    = 4'b0010;
                w_sext    = 1'b1;
                if (!w_is_legal) begin
                    w_illegal = 1'b1;
                    w_next    = S_IF;
                end else if (w_is_j || w_is_jal) begin
                    w_wpc      = 1'b1;
                    w_pcsource = 2'b11;
                    w_jal      = w_is_jal;
                    w_wreg     = w_is_jal;
                    w_retire   = 1'b1;
                    w_next     = S_IF;
                end else if (w_is_jr) begin
                    w_wpc      = 1'b1;
                    w_pcsource = 2'b10;
                    w_retire   = 1'b1;
                    w_next     = S_IF;
                end else begin
                    w_next = S_EXE;
                end
            end
            S_EXE: begin
                w_aluc    = w_dec_aluc;
                w_alusrca = 1'b1;
                w_shift   = w_is_shift;
                w_alusrcb = w_is_imm ? 2'b10 : 2'b00;
                w_sext    = w_is_sext;
                if (w_is_beq || w_is_bne) begin
                    w_wpc      = (w_is_beq & bus.z) | (w_is_bne & ~bus.z);
                    w_pcsource = 2'b01;
                    w_retire   = 1'b1;
                    w_next     = S_IF;
                end else if (w_is_lw || w_is_sw) begin
                    w_next = S_MEM;
                end else begin
                    w_next = S_WB;
                end
            end
            S_MEM: begin
                w_iord = 1'b1;
                if (w_ready) begin
                    if (w_is_sw) begin
                        w_wmem   = 1'b1;
                        w_retire = 1'b1;
                        w_next   = S_IF;
                    end else begin
                        w_next = S_WB;
                    end
                end else if (w_timeout) begin
                    w_next = S_IF;
                end else begin
                    w_next = S_MEM;
                end
            end
            S_WB: begin
                w_wreg   = 1'b1;
                w_regrt  = w_is_regrt;
                w_m2reg  = w_is_lw;
                w_retire = 1'b1;
                w_next   = S_IF;
            end
            default: w_next = S_IF;
        endcase
    end

    // ------------------------------------------------------------- registers
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            r_state       <= S_IF;
            r_wait        <= 8'd0;
            r_mem_timeout <= 1'b0;
            r_icount      <= '0;
        end else begin
            r_state <= w_next;
            // Any state change (normal or abort) leaves w_waiting low or
            // w_timeout high, so both paths clear the counter.
            r_wait  <= (w_waiting && !w_timeout) ? r_wait + 8'd1 : 8'd0;
            if (w_timeout) begin
                r_mem_timeout <= 1'b1;
            end
            if (w_retire) begin
                r_icount <= r_icount + 1'b1;
            end
        end
    end

    // Write strobes are held off while reset is asserted so an aborted
    // instruction cannot commit anything during the reset window.
    assign bus.wpc         = w_wpc  & clrn;
    assign bus.wir         = w_wir  & clrn;
    assign bus.wmem        = w_wmem & clrn;
    assign bus.wreg        = w_wreg & clrn;
    assign bus.iord        = w_iord;
    assign bus.regrt       = w_regrt;
    assign bus.m2reg       = w_m2reg;
    assign bus.shift       = w_shift;
    assign bus.jal         = w_jal;
    assign bus.sext        = w_sext;
    assign bus.alusrca     = w_alusrca;
    assign bus.aluc        = w_aluc;
    assign bus.alusrcb     = w_alusrcb;
    assign bus.pcsource    = w_pcsource;
    assign bus.illegal     = w_illegal;
    assign bus.state       = r_state;
    assign bus.mem_timeout = r_mem_timeout;
    assign bus.icount      = r_icount;
endmodule
`default_nettype wire

// File: doc/multicycle_control_unit.md
MULTICYCLE_CONTROL_UNIT -- requirements
Module: multicycle_control_unit

Interface
REQ-001 SHALL have parameter MEM_HANDSHAKE, default 1, meaning 1 = honour mem_ready, 0 = treat mem_ready as constantly 1.
REQ-002 SHALL have parameter TIMEOUT, default 15, meaning the maximum number of MEM/IF wait cycles before an abort; the range is 1..255.
REQ-003 SHALL have parameter CNT_W, default 32, meaning the width of the retired-instruction counter.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 clrn  input  1  reset, asynchronous and active-low.
REQ-006 op  input  6  opcode; func  input  6  R-type function field; z  input  1  ALU zero flag.
REQ-007 mem_ready  input  1  memory completes the access in the current cycle.
REQ-008 wpc, wir, wmem, wreg, iord, regrt, m2reg, shift, jal, sext, alusrca  output  1 each  datapath strobes and selects.
REQ-009 aluc  output  4;  alusrcb  output  2  (00 reg, 01 const 4, 10 ext imm, 11 ext imm<<2);  pcsource  output  2  (00 pc+4, 01 branch, 10 jr, 11 jump).
REQ-010 state  output  3;  illegal  output  1  (one-cycle pulse);  mem_timeout  output  1  (sticky);  icount  output  CNT_W  (retired instructions).

Function
REQ-011 SHALL implement the states IF=0, ID=1, EXE=2, MEM=3 and WB=4; state shall drive the current encoding.
REQ-012 All outputs SHALL be Moore/Mealy decodes of state, op, func, z and mem_ready; only state, the wait counter, mem_timeout and icount are registered.
REQ-013 The supported set SHALL be: add addu sub subu and or xor nor slt sltu sll srl sra sllv srlv srav jr addi addiu andi ori xori lw sw beq bne slti sltiu lui j jal. Any other op/func is illegal.
REQ-014 aluc SHALL use the following encoding.
- 0000: addu, addiu.
- 0010: add, addi, lw, sw, and the fetch/ID adds.
- 0011: sub, beq, bne.
- 0001: subu.
- 0100: and, andi.
- 0101: or, ori.
- 0110: xor, xori.
- 0111: nor.
- 1011: slt, slti.
- 1010: sltu, sltiu.
- 1110: sll, sllv.
- 1111: srl, srlv.
- 1100: sra, srav.
- 1000: lui.
REQ-015 IF SHALL drive iord=0, alusrca=0, alusrcb=01, aluc=0010 and pcsource=00; wir=wpc=mem_ready; on mem_ready the state goes to ID, otherwise it stays in IF.
REQ-016 ID SHALL drive alusrca=0, alusrcb=11, aluc=0010 and sext=1.
- j: wpc=1, pcsource=11, next state IF.
- jal: wpc=1, pcsource=11, jal=1, wreg=1, next state IF.
- jr: wpc=1, pcsource=10, next state IF.
- illegal: illegal=1, no write strobes, next state IF.
- All others: next state EXE.
REQ-017 EXE SHALL drive aluc per REQ-014.
- alusrca=1 for register operands; shift=1 for sll, srl and sra.
- alusrcb=10 for I-type; sext=1 for addi, addiu, lw, sw, beq, bne, slti and sltiu; sext=0 for andi, ori, xori and lui.
- beq/bne: wpc=(beq&z)|(bne&~z), pcsource=01, next state IF.
- lw/sw: next state MEM.
- Others: next state WB.
REQ-018 MEM SHALL drive iord=1.
- sw: wmem=mem_ready; on mem_ready the next state is IF.
- lw: on mem_ready the next state is WB.
- Without mem_ready the state stays in MEM.
REQ-019 WB SHALL drive wreg=1; regrt=1 for all I-type writers (addi addiu andi ori xori slti sltiu lui lw); m2reg=1 for lw; next state IF.
REQ-020 Write strobes (wpc, wir, wmem, wreg) SHALL be 0 in every state/instruction combination not listed above.
REQ-021 A wait counter SHALL count consecutive cycles in IF or MEM with mem_ready=0 and clear on any state change.
- If it reaches TIMEOUT, the FSM SHALL go to IF with no write strobes asserted.
- mem_timeout SHALL set and stay at 1 until reset.
REQ-022 icount SHALL increment by 1 on every transition into IF from ID, EXE, MEM or WB, except illegal-instruction and timeout returns.
- It SHALL wrap modulo 2^CNT_W.
REQ-023 With MEM_HANDSHAKE=0 the timing SHALL be fixed: IF and MEM are one cycle each, and no timeout can occur.

Reset
REQ-024 While clrn=0, asynchronously: state=IF, wait counter=0, mem_timeout=0, icount=0.
REQ-025 A reset asserted in any state, including mid-wait in MEM, SHALL abort the instruction with no further write strobes; the first rising edge after release starts in IF.

Verification
REQ-026 add ($op=0, func=0x20), mem_ready=1 -> states IF,ID,EXE,WB,IF; aluc=0010 in EXE; wreg=1, regrt=0 in WB; icount 0->1.
REQ-027 lw (op=0x23) with mem_ready low for 3 MEM cycles -> MEM held 4 cycles; WB has m2reg=1, regrt=1, wreg=1; total 8 cycles.
REQ-028 beq (op=0x04): z=1 -> wpc=1, pcsource=01 in EXE. Then bne with z=1 -> wpc=0; both return to IF after 3 cycles.
REQ-029 jal (op=0x03) -> ID asserts wpc, jal and wreg, pcsource=11; next state IF; icount increments.
REQ-030 op=0x3F -> illegal pulses for one cycle in ID; no write strobes; icount unchanged. Then sw with mem_ready held 0 (TIMEOUT=15) -> return to IF after 15 MEM cycles, mem_timeout=1, wmem never 1.
REQ-031 clrn pulsed low mid-MEM -> state=0 immediately, icount=0, mem_timeout=0.
